// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_pkg : shared widths, redirect opcodes and fetch-state encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [3:0] OpJump  = 4'h8;
    localparam logic [3:0] OpJumpf = 4'h9;
    localparam logic [3:0] OpCall  = 4'hA;
    localparam logic [3:0] OpRet   = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic is_redirect_op(input logic [3:0] op);
        return (op == OpJump) || (op == OpJumpf) || (op == OpCall) || (op == OpRet);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fq_fifo : DEPTH-entry circular buffer of {pc, inst} with synchronous clear
// Rev 1.0
// ----------------------------------------------------------------------------
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_pc,
    input  logic [DW-1:0] i_push_inst,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic [AW-1:0] o_head_pc,
    output logic [DW-1:0] o_head_inst
);

    logic [AW-1:0] r_mem_pc   [DEPTH];
    logic [DW-1:0] r_mem_inst [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Storage is reset too so the head outputs read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= '0;
                r_mem_inst[i] <= '0;
            end
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem_pc[r_tail]   <= i_push_pc;
                r_mem_inst[r_tail] <= i_push_inst;
                r_tail             <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid     = (r_count != '0);
    assign o_count     = r_count;
    assign o_head_pc   = r_mem_pc[r_head];
    assign o_head_inst = r_mem_inst[r_head];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : sequential instruction fetch with redirect flush and FIFO
// Optional macro FETCH_BYPASS_EN: empty-queue response drives outputs directly.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W,
    parameter int DW    = WORD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc,
    output logic [DW-1:0] out_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [AW-1:0] r_fetch_pc;
    logic          r_inflight;
    logic [AW-1:0] r_req_addr;
    logic          r_req_epoch;
    logic          r_epoch;

    logic          w_redir;
    logic          w_room;
    logic          w_resp_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_valid;
    logic [CW-1:0] w_count;
    logic [AW-1:0] w_head_pc;
    logic [DW-1:0] w_head_inst;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = RUN;
            RUN:     if (halt)  w_state_nxt = HOLD;
            HOLD:    if (!halt) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_redir   = redirect && (r_state != IDLE);
    assign w_room    = (w_count + CW'(r_inflight)) < CW'(DEPTH);
    assign imem_req  = !halt && (((r_state == RUN) && w_room) || w_redir);
    assign imem_addr = w_redir ? redirect_pc : r_fetch_pc;

    // The request tag carries the post-redirect epoch so its reply survives the flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc  <= '0;
            r_inflight  <= 1'b0;
            r_req_addr  <= '0;
            r_req_epoch <= 1'b0;
            r_epoch     <= 1'b0;
        end else begin
            if (imem_req) begin
                r_fetch_pc <= imem_addr + AW'(1);
                r_req_addr <= imem_addr;
            end else if (w_redir) begin
                r_fetch_pc <= redirect_pc;
            end
            r_inflight  <= imem_req;
            r_req_epoch <= r_epoch ^ w_redir;
            r_epoch     <= r_epoch ^ w_redir;
        end
    end

    assign w_resp_ok = r_inflight && imem_valid && (r_req_epoch == r_epoch) && !w_redir;
    assign w_pop     = w_fifo_valid && out_ready && !w_redir;

`ifdef FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp     = w_resp_ok && !w_fifo_valid;
    assign w_push    = w_resp_ok && !(w_byp && out_ready);
    assign out_valid = !w_redir && (w_fifo_valid || w_byp);
    assign out_pc    = w_byp ? r_req_addr : w_head_pc;
    assign out_inst  = w_byp ? imem_data  : w_head_inst;
`else
    assign w_push    = w_resp_ok;
    assign out_valid = !w_redir && w_fifo_valid;
    assign out_pc    = w_head_pc;
    assign out_inst  = w_head_inst;
`endif

    fq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_redir),
        .i_push      (w_push),
        .i_push_pc   (r_req_addr),
        .i_push_inst (imem_data),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_count     (w_count),
        .o_head_pc   (w_head_pc),
        .o_head_inst (w_head_inst)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue : directed bench for fetch_queue with a 1-cycle memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_inst;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_pc;

    fetch_queue #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word at address k is 16'h1000 + k, returned one cycle after the request.
    always @(posedge clk) begin
        imem_valid <= imem_req;
        imem_data  <= 16'h1000 + imem_addr;
    end

    // A push into a full queue without a simultaneous pop must never happen.
    always @(negedge clk) begin
        if (reset && dut.w_push) begin
            n_checks++;
            assert (!(dut.w_count == 3'd4 && !dut.w_pop)) else begin
                n_err++;
                $error("FAIL push_full observed=count%0d expected=room", dut.w_count);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        logic [15:0] inst;
        inst = 16'h1000 + pc;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"},    {16'd0, out_pc},    {16'd0, pc});
        chk({tag, "_inst"},  {16'd0, out_inst},  {16'd0, inst});
    endtask

    initial begin
        reset       = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b1;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;

        // Reset state
        nxt();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc",    {16'd0, out_pc},    32'd0);
        chk("rst_inst",  {16'd0, out_inst},  32'd0);
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_addr",  {16'd0, imem_addr}, 32'd0);

        // 1: cold start, first out_valid on the third cycle after release
        reset = 1'b1;
        nxt();
        chk("c1_req",   {31'd0, imem_req},  32'd1);
        chk("c1_addr",  {16'd0, imem_addr}, 32'd0);
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        nxt();
        chk("c2_valid", {31'd0, out_valid}, 32'd0);
        nxt();
        exp_pc = 16'h0000;
        chk_head("c3", exp_pc);
        for (int i = 0; i < 6; i++) begin
            nxt();
            exp_pc = exp_pc + 16'd1;
            chk_head("stream", exp_pc);
        end

        // 2: stall, queue fills to 4 and requests stop
        out_ready = 1'b0;
        nxt();
        chk("stall1_pc", {16'd0, out_pc}, {16'd0, exp_pc});
        nxt();
        chk("stall2_req", {31'd0, imem_req}, 32'd0);
        repeat (8) nxt();
        chk_head("stall_end", exp_pc);
        chk("stall_end_req", {31'd0, imem_req}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nxt();
            exp_pc = exp_pc + 16'd1;
            chk_head("drain", exp_pc);
        end

        // 3: three queued plus one in flight, then redirect to 0x0040
        out_ready = 1'b0;
        nxt();
        chk("pre_redir_req", {31'd0, imem_req}, 32'd0);
        chk("pre_redir_pc",  {16'd0, out_pc},   {16'd0, exp_pc});
        redirect    = is_redirect_op(OpJump);
        redirect_pc = 16'h0040;
        out_ready   = 1'b1;
        #1;
        chk("redir_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_req",   {31'd0, imem_req},  32'd1);
        chk("redir_addr",  {16'd0, imem_addr}, 32'h0040);
        nxt();
        redirect = 1'b0;
        chk("redir_n1_valid", {31'd0, out_valid}, 32'd0);
        exp_pc = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk_head("after_redir", exp_pc);
            exp_pc = exp_pc + 16'd1;
        end

        // 4: redirect near the top of the address space wraps
        redirect    = is_redirect_op(OpRet);
        redirect_pc = 16'hFFFE;
        #1;
        chk("wrap_redir_valid", {31'd0, out_valid}, 32'd0);
        nxt();
        redirect = 1'b0;
        chk("wrap_n1_valid", {31'd0, out_valid}, 32'd0);
        exp_pc = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk_head("wrap", exp_pc);
            if (i < 3) exp_pc = exp_pc + 16'd1;
        end

        // 5: halt for 5 cycles; the in-flight word still arrives
        halt = 1'b1;
        #1;
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        nxt();
        exp_pc = exp_pc + 16'd1;
        chk_head("halt_inflight", exp_pc);
        nxt();
        chk("halt_empty", {31'd0, out_valid}, 32'd0);
        repeat (3) nxt();
        chk("halt_end_req", {31'd0, imem_req}, 32'd0);
        halt = 1'b0;
        #1;
        chk("hold_exit_req", {31'd0, imem_req}, 32'd0);
        nxt();
        exp_pc = exp_pc + 16'd1;
        chk("resume_req",  {31'd0, imem_req},  32'd1);
        chk("resume_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
        nxt();
        chk("resume_n1_valid", {31'd0, out_valid}, 32'd0);
        nxt();
        chk_head("resume", exp_pc);

        // 6: asynchronous reset while full
        out_ready = 1'b0;
        repeat (6) nxt();
        chk("full_valid", {31'd0, out_valid}, 32'd1);
        chk("full_req",   {31'd0, imem_req},  32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_req",   {31'd0, imem_req},  32'd0);
        chk("async_pc",    {16'd0, out_pc},    32'd0);
        chk("async_inst",  {16'd0, out_inst},  32'd0);
        chk("async_addr",  {16'd0, imem_addr}, 32'd0);
        nxt();
        nxt();
        out_ready = 1'b1;
        reset     = 1'b1;
        nxt();
        chk("rs_c1_req",  {31'd0, imem_req},  32'd1);
        chk("rs_c1_addr", {16'd0, imem_addr}, 32'd0);
        nxt();
        chk("rs_c2_valid", {31'd0, out_valid}, 32'd0);
        nxt();
        chk_head("rs_c3", 16'h0000);
        nxt();
        chk_head("rs_c4", 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
